note_judge: RTL and testbench

- Receiving end of the note lane: consumes the lane's target-slot indication and the player's button, and judges each note that reaches the target slot (LED8) as PERFECT, GOOD or MISS.
- Keeps score, current combo and maximum combo, and emits one-cycle event pulses for the display and sound blocks.
- Sits between the note lane and the score/FND display logic and shares the 1 ms tick from clk_div.

---
 rtl/note_judge.sv | 196 +++++++++++++++++++
 tb/tb_note_judge.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/note_judge.sv
// note_judge: judges each note reaching the lane target slot as PERFECT, GOOD
// or MISS, keeps score / combo / max combo and pulses hit, miss and empty events.
// Build option: define JUDGE_DEBOUNCE_EN to add a tick-based button debounce;
// the DEBOUNCE_MS parameter exists only in that build.
module note_judge #(
  parameter int unsigned PERFECT_MS  = 50,
  parameter int unsigned PERFECT_PTS = 10,
  parameter int unsigned GOOD_PTS    = 5
`ifdef JUDGE_DEBOUNCE_EN
  ,
  parameter int unsigned DEBOUNCE_MS = 10
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_tick,
  input  logic        i_step,
  input  logic        i_is_target,
  input  logic        i_btn,
  output logic        o_hit,
  output logic        o_miss,
  output logic        o_empty,
  output logic [1:0]  o_grade,
  output logic [15:0] o_score,
  output logic [7:0]  o_combo,
  output logic [7:0]  o_max_combo
);

  localparam int unsigned SCORE_W = 16;
  localparam int unsigned COMBO_W = 8;
  localparam int unsigned MS_W    = 8;

  localparam logic [1:0] GRADE_PERFECT = 2'b01;
  localparam logic [1:0] GRADE_GOOD    = 2'b10;
  localparam logic [1:0] GRADE_MISS    = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WINDOW = 2'd1,
    JUDGED = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 step_dly_q;
  logic                 btn_s1_q, btn_s2_q, btn_prev_q;
  logic                 btn_lvl_c, press_c, open_c;
  logic [MS_W-1:0]      ms_q, ms_d;
  logic                 hit_q, hit_d, miss_q, miss_d, empty_q, empty_d;
  logic [1:0]           grade_q, grade_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [COMBO_W-1:0]   combo_q, combo_d, max_q, max_d;
  logic                 perfect_c;
  logic [SCORE_W-1:0]   pts_c;
  logic [SCORE_W:0]     score_sum_c;
  logic [COMBO_W-1:0]   combo_inc_c;

  // button synchronizer, edge-detect history and lane step delay
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1_q   <= 1'b0;
      btn_s2_q   <= 1'b0;
      btn_prev_q <= 1'b0;
      step_dly_q <= 1'b0;
    end else begin
      btn_s1_q   <= i_btn;
      btn_s2_q   <= btn_s1_q;
      btn_prev_q <= btn_lvl_c;
      step_dly_q <= i_step;
    end
  end

`ifdef JUDGE_DEBOUNCE_EN
  localparam int unsigned DB_W = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
  logic [DB_W-1:0] db_cnt_q;
  logic            btn_db_q;

  // accept the synchronized level only after it holds for DEBOUNCE_MS ticks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt_q <= '0;
      btn_db_q <= 1'b0;
    end else if (btn_s2_q == btn_db_q) begin
      db_cnt_q <= '0;
    end else if (i_tick) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_MS - 1)) begin
        btn_db_q <= btn_s2_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + DB_W'(1);
      end
    end
  end

  assign btn_lvl_c = btn_db_q;
`else
  assign btn_lvl_c = btn_s2_q;
`endif

  assign press_c = btn_lvl_c & ~btn_prev_q;
  assign open_c  = step_dly_q & i_is_target;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // next state: a step closes the current note, a press in WINDOW judges it
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (open_c) state_d = WINDOW;
      WINDOW: begin
        if (step_dly_q)   state_d = i_is_target ? WINDOW : IDLE;
        else if (press_c) state_d = JUDGED;
      end
      JUDGED:  if (step_dly_q) state_d = i_is_target ? WINDOW : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // judgement, scoring and window timer next values
  always_comb begin
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    empty_d     = 1'b0;
    grade_d     = grade_q;
    score_d     = score_q;
    combo_d     = combo_q;
    max_d       = max_q;
    ms_d        = ms_q;
    perfect_c   = 32'(ms_q) < PERFECT_MS;
    pts_c       = perfect_c ? SCORE_W'(PERFECT_PTS) : SCORE_W'(GOOD_PTS);
    score_sum_c = {1'b0, score_q} + {1'b0, pts_c};
    combo_inc_c = (combo_q == '1) ? combo_q : combo_q + COMBO_W'(1);

    // tick in the press cycle lands after the grade, which reads ms_q
    if (state_q == WINDOW && i_tick && ms_q != '1) ms_d = ms_q + MS_W'(1);
    if (open_c) ms_d = '0;

    case (state_q)
      IDLE: begin
        if (press_c) begin
          empty_d = 1'b1;
          combo_d = '0;
        end
      end
      WINDOW: begin
        if (press_c) begin
          hit_d   = 1'b1;
          grade_d = perfect_c ? GRADE_PERFECT : GRADE_GOOD;
          score_d = score_sum_c[SCORE_W] ? '1 : score_sum_c[SCORE_W-1:0];
          combo_d = combo_inc_c;
          if (combo_inc_c > max_q) max_d = combo_inc_c;
        end else if (step_dly_q) begin
          miss_d  = 1'b1;
          grade_d = GRADE_MISS;
          combo_d = '0;
        end
      end
      default: ;
    endcase
  end

  // registered outputs and window timer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      empty_q <= 1'b0;
      grade_q <= '0;
      score_q <= '0;
      combo_q <= '0;
      max_q   <= '0;
      ms_q    <= '0;
    end else begin
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      empty_q <= empty_d;
      grade_q <= grade_d;
      score_q <= score_d;
      combo_q <= combo_d;
      max_q   <= max_d;
      ms_q    <= ms_d;
    end
  end

  assign o_hit       = hit_q;
  assign o_miss      = miss_q;
  assign o_empty     = empty_q;
  assign o_grade     = grade_q;
  assign o_score     = score_q;
  assign o_combo     = combo_q;
  assign o_max_combo = max_q;

endmodule

// File: tb/tb_note_judge.sv
// tb_note_judge: directed and random note/press/tick sequences for note_judge,
// checked against an event-level model of the judging rules.
module tb_note_judge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_tick = 1'b0;
  logic        i_step = 1'b0;
  logic        i_is_target = 1'b0;
  logic        i_btn = 1'b0;
  logic        o_hit, o_miss, o_empty;
  logic [1:0]  o_grade;
  logic [15:0] o_score;
  logic [7:0]  o_combo, o_max_combo;

  int total = 0;
  int bad   = 0;
  int seen_hit = 0, seen_miss = 0, seen_empty = 0;

  localparam int P_MS  = 50;
  localparam int P_PTS = 10;
  localparam int G_PTS = 5;
  localparam int M_IDLE = 0, M_WIN = 1, M_JUD = 2;

  int m_st, m_ms, m_score, m_combo, m_max, m_grade;
  int m_hit = 0, m_miss = 0, m_empty = 0;

  always #5 clk = ~clk;

  note_judge dut (
    .clk         (clk),
    .rst         (rst),
    .i_tick      (i_tick),
    .i_step      (i_step),
    .i_is_target (i_is_target),
    .i_btn       (i_btn),
    .o_hit       (o_hit),
    .o_miss      (o_miss),
    .o_empty     (o_empty),
    .o_grade     (o_grade),
    .o_score     (o_score),
    .o_combo     (o_combo),
    .o_max_combo (o_max_combo)
  );

  // count event pulses; a stretched pulse is counted more than once
  always @(negedge clk) begin
    if (o_hit)   seen_hit++;
    if (o_miss)  seen_miss++;
    if (o_empty) seen_empty++;
  end

  // ---------------- reference model ----------------
  task automatic m_reset();
    m_st = M_IDLE; m_ms = 0; m_score = 0; m_combo = 0; m_max = 0; m_grade = 0;
  endtask

  task automatic m_press();
    if (m_st == M_IDLE) begin
      m_empty++;
      m_combo = 0;
    end else if (m_st == M_WIN) begin
      m_hit++;
      if (m_ms < P_MS) begin m_grade = 1; m_score += P_PTS; end
      else             begin m_grade = 2; m_score += G_PTS; end
      if (m_score > 65535) m_score = 65535;
      if (m_combo < 255) m_combo++;
      if (m_combo > m_max) m_max = m_combo;
      m_st = M_JUD;
    end
  endtask

  task automatic m_step(input bit tgt);
    if (m_st == M_WIN) begin
      m_miss++;
      m_grade = 3;
      m_combo = 0;
    end
    m_st = tgt ? M_WIN : M_IDLE;
    if (tgt) m_ms = 0;
  endtask

  task automatic m_tick();
    if (m_st == M_WIN && m_ms < 255) m_ms++;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    #1;
    chk({tag, ".hits"},   seen_hit,    m_hit);
    chk({tag, ".misses"}, seen_miss,   m_miss);
    chk({tag, ".empties"},seen_empty,  m_empty);
    chk({tag, ".grade"},  o_grade,     m_grade);
    chk({tag, ".score"},  o_score,     m_score);
    chk({tag, ".combo"},  o_combo,     m_combo);
    chk({tag, ".max"},    o_max_combo, m_max);
  endtask

  // ---------------- stimulus ----------------
  task automatic do_step(input bit tgt);
    @(negedge clk); i_step = 1'b1; i_is_target = tgt;
    @(negedge clk); i_step = 1'b0;
    repeat (2) @(negedge clk);
    m_step(tgt);
  endtask

  task automatic do_press();
    @(negedge clk); i_btn = 1'b1;
    repeat (4) @(negedge clk);
    i_btn = 1'b0;
    repeat (3) @(negedge clk);
    m_press();
  endtask

  task automatic do_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); i_tick = 1'b1;
      @(negedge clk); i_tick = 1'b0;
      m_tick();
    end
  endtask

  // tick lands in the same clock as the press is judged
  task automatic do_press_tick();
    @(negedge clk); i_btn = 1'b1;
    @(negedge clk);
    @(negedge clk); i_tick = 1'b1;
    @(negedge clk); i_tick = 1'b0;
    @(negedge clk); i_btn = 1'b0;
    repeat (3) @(negedge clk);
    m_press();
    m_tick();
  endtask

  // delayed step lands in the same clock as the press is judged
  task automatic do_press_step(input bit tgt);
    @(negedge clk); i_btn = 1'b1;
    @(negedge clk); i_step = 1'b1; i_is_target = tgt;
    @(negedge clk); i_step = 1'b0;
    @(negedge clk);
    @(negedge clk); i_btn = 1'b0;
    repeat (3) @(negedge clk);
    m_press();
    m_step(tgt);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    m_reset();
  endtask

  initial begin
    m_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst = 1'b1;

    // PERFECT at 20 ms
    do_step(1); do_ticks(20); do_press(); check_all("perfect20");

    // GOOD at 120 ms, then a second press in the same window is ignored
    do_step(1); do_ticks(120); do_press(); check_all("good120");
    do_press(); check_all("judged_press");

    // unpressed note leaves the slot
    do_step(1); do_step(0); check_all("miss_idle");

    // back-to-back notes: hit, hit, miss; second window timer restarts
    do_step(1); do_ticks(60); do_press(); check_all("b2b_hit1");
    do_step(1); do_ticks(10); do_press(); check_all("b2b_hit2");
    do_step(1); do_step(1); check_all("b2b_miss");
    do_step(0); check_all("b2b_miss2");

    // press with no note, combo built to 4
    for (int n = 0; n < 4; n++) begin do_step(1); do_press(); end
    do_step(0); check_all("combo4");
    do_press(); check_all("empty_press");

    // grade boundaries and window timer saturation
    do_step(1); do_ticks(49); do_press_tick(); check_all("ms49_tick");
    do_step(1); do_ticks(50); do_press(); check_all("ms50");
    do_step(1); do_ticks(300); do_press(); check_all("ms_sat");
    do_step(0);

    // press and closing step together
    do_step(1); do_ticks(5); do_press_step(1); check_all("press_step_reopen");
    do_step(0); check_all("reopened_miss");
    do_step(1); do_press_step(0); check_all("press_step_close");
    do_press(); check_all("after_close_empty");

    // random note traffic
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 3)      do_step(1'($urandom_range(0, 1)));
      else if (r < 6) do_press();
      else            do_ticks(int'($urandom_range(1, 30)));
      check_all("rnd");
    end
    do_step(0);

    // score and combo saturation via back-to-back fast notes
    do_reset();
    i_is_target = 1'b1;
    for (int n = 0; n < 6553; n++) begin
      @(negedge clk); i_step = 1'b1; i_btn = 1'b1;
      @(negedge clk); i_step = 1'b0; i_btn = 1'b0;
      m_step(1);
      m_press();
    end
    repeat (3) @(negedge clk);
    check_all("score65530");
    do_step(1); do_press(); check_all("score_sat");
    do_step(1); do_press(); check_all("score_hold");

    // asynchronous reset in the middle of a window
    do_step(1); do_ticks(5);
    @(negedge clk); #2 rst = 1'b0;
    #1;
    chk("async.hit",   o_hit,       0);
    chk("async.miss",  o_miss,      0);
    chk("async.empty", o_empty,     0);
    chk("async.grade", o_grade,     0);
    chk("async.score", o_score,     0);
    chk("async.combo", o_combo,     0);
    chk("async.max",   o_max_combo, 0);
    m_reset();
    @(negedge clk); rst = 1'b1;
    do_step(0); check_all("post_reset_step");
    repeat (4) @(negedge clk);
    check_all("post_reset_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
